// File: rtl/memory_loader_pkg.sv
// Shared types and sizes for the boot-time memory loader and its word RAM.
// The packed register bundle keeps all loader state in one two-phase register.
package memory_loader_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int WORD_WIDTH = 15;
  localparam int HI_WIDTH   = 7;

  typedef enum logic [1:0] {
    COUNT,
    HI,
    LO,
    RUN
  } loader_state_t;

  typedef struct packed {
    loader_state_t       state;
    logic [7:0]          loaded;
    logic [7:0]          count;
    logic [HI_WIDTH-1:0] pending;
    logic                cpuReset;
  } loader_regs_t;

  localparam loader_regs_t LOADER_RESET = '{
    state:    COUNT,
    loaded:   8'd0,
    count:    8'd0,
    pending:  '0,
    cpuReset: 1'b1
  };

endpackage

// File: rtl/memory_loader_ram_2p15.sv
// Word RAM with an asynchronous read port and a ph2-sampled write port.
// The two byte lanes let the processor rewrite only the low byte of a word.
module ram_2p15
  import memory_loader_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             ph2,
  input  logic             writeEn_i,
  input  logic [1:0]       laneEn_i,
  input  logic [7:0]       writeAdr_i,
  input  logic [WIDTH-1:0] writeData_i,
  input  logic [7:0]       readAdr_i,
  output logic [WIDTH-1:0] readData_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // laneEn_i[1] covers the high slice, laneEn_i[0] the low byte
  always_ff @(posedge ph2) begin
    if (writeEn_i) begin
      if (laneEn_i[1]) mem[writeAdr_i][WIDTH-1:8] <= writeData_i[WIDTH-1:8];
      if (laneEn_i[0]) mem[writeAdr_i][7:0]       <= writeData_i[7:0];
    end
  end

  assign readData_o = mem[readAdr_i];

endmodule

// File: rtl/memory_loader.sv
// Streams a byte-serial program image into the word RAM while holding the CPU in
// reset, then hands the RAM to the processor over the Adr/MemData bus.
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [7:0]       Adr,
  output logic [WIDTH-9:0] MemData1,
  inout  wire  [7:0]       MemData2,
  input  logic             LoadValid,
  input  logic [7:0]       LoadByte,
  output logic             LoadReady,
  output logic             CpuReset,
  output logic [7:0]       Loaded
);

  loader_regs_t     regsPh2_q, regs_q, regs_d;
  logic             accept, loaderWe, cpuWe, ramWe, busDrive;
  logic [1:0]       laneEn;
  logic [7:0]       ramAdr, loadedInc;
  logic [WIDTH-1:0] ramWrData, ramRdData;

  // Two-phase register: sampled at ph2, presented to the logic at ph1
  always_ff @(posedge ph2) begin
    regsPh2_q <= reset ? LOADER_RESET : regs_d;
  end

  always_ff @(posedge ph1) begin
    regs_q <= regsPh2_q;
  end

  // A count byte of 0 means 256 words: the 8-bit Loaded wraps back to 0 to match
  always_comb begin
    regs_d    = regs_q;
    loadedInc = regs_q.loaded + 8'd1;
    if (accept) begin
      case (regs_q.state)
        COUNT: begin
          regs_d.count  = LoadByte;
          regs_d.loaded = 8'd0;
          regs_d.state  = HI;
        end
        HI: begin
          regs_d.pending = LoadByte[HI_WIDTH-1:0];
          regs_d.state   = LO;
        end
        LO: begin
          regs_d.loaded = loadedInc;
          regs_d.state  = (loadedInc == regs_q.count) ? RUN : HI;
        end
        default: ;
      endcase
    end
    regs_d.cpuReset = (regs_d.state != RUN);
  end

  // Reset wins over a presented byte, so nothing is accepted or written in that cycle
  always_comb begin
    LoadReady = reset || (regs_q.state != RUN);
    accept    = LoadValid && LoadReady && !reset;
    loaderWe  = accept && (regs_q.state == LO);
    cpuWe     = !reset && (regs_q.state == RUN) && MemWrite;
    ramWe     = loaderWe || cpuWe;
    laneEn    = loaderWe ? 2'b11 : 2'b01;
    ramAdr    = loaderWe ? regs_q.loaded : Adr;
    ramWrData = loaderWe ? {regs_q.pending, LoadByte} : {{HI_WIDTH{1'b0}}, MemData2};
    busDrive  = (regs_q.state == RUN) && !MemWrite;
  end

  ram_2p15 #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_ram (
    .ph2        (ph2),
    .writeEn_i  (ramWe),
    .laneEn_i   (laneEn),
    .writeAdr_i (ramAdr),
    .writeData_i(ramWrData),
    .readAdr_i  (Adr),
    .readData_o (ramRdData)
  );

  assign MemData1  = ramRdData[WIDTH-1:8];
  assign MemData2  = busDrive ? ramRdData[7:0] : 8'hzz;
  assign CpuReset  = regs_q.cpuReset;
  assign Loaded    = regs_q.loaded;

endmodule

// File: doc/memory_loader.md
MEMORY_LOADER -- requirements
Module: memory_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 15-bit program/data words, addressed by Adr.
REQ-002 The block SHALL have parameter WIDTH, default 15, meaning word width: high slice [14:8], low byte [7:0].
REQ-003 ph1  input  1  first non-overlapping clock phase; flop outputs update during ph1.
REQ-004 ph2  input  1  second clock phase; flop inputs, reset and handshakes sampled during ph2.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 MemWrite  input  1  processor data-write strobe.
REQ-007 Adr  input  8  processor word address.
REQ-008 MemData1  output  7  bits [14:8] of mem[Adr].
REQ-009 MemData2  inout  8  bits [7:0]: block drives when reading, processor drives when MemWrite=1.
REQ-010 LoadValid  input  1  loader byte valid.
REQ-011 LoadByte  input  8  loader byte.
REQ-012 LoadReady  output  1  block accepts a byte this cycle.
REQ-013 CpuReset  output  1  holds the processor in reset; tie to the processor reset input.
REQ-014 Loaded  output  8  count of words written by the current load.

Function
REQ-015 The FSM SHALL have states COUNT, HI, LO, RUN; a byte is accepted in any cycle with LoadValid & LoadReady at ph2.
REQ-016 LoadReady SHALL be 1 in COUNT, HI and LO, and 0 in RUN.
REQ-017 On accepting a byte in COUNT: N <= LoadByte, where 0 means 256; state -> HI; Loaded <= 0.
REQ-018 On accepting a byte in HI: hold LoadByte[6:0] as the pending high slice; LoadByte[7] is ignored; state -> LO.
REQ-019 On accepting a byte in LO: write {pending, LoadByte} to mem[Loaded]; Loaded += 1.
REQ-020 After the LO write, state -> RUN if the incremented Loaded equals N mod 256, else -> HI.
REQ-021 Loaded SHALL be 8 bits wide and wrap 255->0; for N=256 the terminal check therefore matches at Loaded = 0.
REQ-022 Without LoadValid, the state and all registers SHALL hold; there is no timeout.
REQ-023 CpuReset SHALL be registered: 1 in every state except RUN; it falls in the cycle after the final LO byte is accepted.
REQ-024 Reads SHALL be combinational from Adr: MemData1 = mem[Adr][14:8], and MemData2 = mem[Adr][7:0] when state = RUN and MemWrite = 0.
REQ-025 In all other cases the block SHALL leave MemData2 high-impedance.
REQ-026 A processor write (RUN & MemWrite) SHALL update only mem[Adr][7:0] from MemData2, latched during ph2; bits [14:8] are unchanged.
REQ-027 A read in the cycle after a write SHALL return the new data.
REQ-028 MemWrite SHALL be ignored outside RUN.
REQ-029 The FSM SHALL leave RUN only on reset.
REQ-030 LoadValid in RUN SHALL have no effect.

Reset
REQ-031 On reset, sampled at ph2: state <= COUNT; Loaded <= 0; N <= 0; pending <= 0; CpuReset <= 1.
REQ-032 In the reset cycle: LoadReady = 1, and a byte presented in that cycle is not accepted.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset mid-load SHALL abandon the load, keep already-written words, and restart at COUNT.

Structure
REQ-035 The shared package SHALL hold: the loader_state_t enum (COUNT, HI, LO, RUN), MEM_DEPTH = 256, WORD_WIDTH = 15, and HI_WIDTH = 7.
REQ-036 Storage SHALL be a sub-module ram_2p15 with one asynchronous read port, a ph2-latched write port, and a 2-bit byte-lane enable (hi, lo).
REQ-037 Loader writes SHALL enable both lanes; processor writes SHALL enable lo only.
REQ-038 The FSM, counters and tristate logic SHALL live in memory_loader; all state registers SHALL use the team's ph1/ph2 flop style.

Verification
REQ-039 Load: stream 02, 41, 23, 05, 7F -> mem[0]=0x4123, mem[1]=0x057F.
REQ-040 Load (cont.): CpuReset falls one cycle after the 0x7F byte is accepted; Loaded=2.
REQ-041 Backpressure: LoadValid toggled 1/0 each cycle during a 3-word load -> identical memory image; state holds on idle cycles.
REQ-042 Run access: after load, Adr=01 read -> MemData1=0x05, MemData2=0x7F.
REQ-043 Run access (cont.): MemWrite with MemData2=0xAA at Adr=01, then read Adr=01 -> MemData1=0x05, MemData2=0xAA.
REQ-044 Reset mid-load: reset after 1 of 3 words -> COUNT, Loaded=0, CpuReset=1, mem[0] retained.
REQ-045 Reset mid-load (cont.): a new 1-word load then completes normally.
REQ-046 Wrap: count byte 00 followed by 512 bytes -> 256 words written, Loaded wraps to 0, enters RUN; mem[255] holds the last word.
REQ-047 Isolation: MemWrite=1 during load at Adr=00 -> mem[00] unchanged and MemData2 undriven by the block.
REQ-048 Isolation (cont.): LoadValid in RUN -> no memory change, LoadReady=0.
